i2c_dice_regs: RTL and testbench
================================

Name: i2c_dice_regs

Overview:
Register bank sitting directly downstream of the I2C slave. It consumes the slave's application interface (rw/addr/wen/wdata/rdata_used/rdata) and exposes a memory-mapped dice roller to an I2C master. A CTRL write starts a roll of an N-sided die. A free-running LFSR is reduced modulo N by an iterative subtract FSM. The result is readable over I2C and also presented on ports for the 7-segment path.

Parameters:
ID_VALUE, 8'hD1, constant returned by register 0x00
LFSR_RESET, 16'hACE1, LFSR value after reset (must be nonzero)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rw  input  1  slave transaction direction (1 = read); informational only, no state depends on it
addr  input  8  register address from slave
wen  input  1  one-cycle write strobe; addr/wdata valid in same cycle
wdata  input  8  write data
rdata_used  input  1  one-cycle pulse: slave has latched current rdata byte
rdata  output  8  read data, registered
result  output  8  last roll result, 1..N
result_valid  output  1  one-cycle pulse when a roll completes
busy  output  1  roll in progress

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset values: rdata=0x00, result=0x00, result_valid=0, busy=0. Internal: sides=0x00, DONE/ERR/OVR=0, scratch=0x00, lfsr=LFSR_RESET, hold=0, state=IDLE.
- Reset mid-roll aborts immediately to the reset values above.
- Register map:
  - 0x00 ID: RO, ID_VALUE.
  - 0x01 CTRL: RW, sides. A write starts a roll.
  - 0x02 STATUS: RO. {4'b0, OVR, ERR, DONE, BUSY}.
  - 0x03 RESULT: RO.
  - 0x04 SEED: WO. Reads return 0x00.
  - 0x05 SCRATCH: RW.
  - Other addresses: reads return 0xFF; writes ignored.
- rdata: rdata <= mux(addr) every cycle. One-cycle latency from addr change.
- LFSR: 16-bit Galois, right shift, taps mask 0xB400. Advances every cycle while hold=0.
- SEED write: lfsr <= {wdata, ~wdata} (never zero); hold <= 1. Legal while busy; does not affect a roll in progress.
- CTRL write, state IDLE, wdata>=2:
  - sides <= wdata; rem <= lfsr[7:0] as sampled in the wen cycle; hold <= 0; state <= REDUCE; BUSY <= 1; DONE <= 0.
- CTRL write, state IDLE, wdata<2: sides <= wdata; ERR <= 1; no roll starts; hold unchanged.
- CTRL write while BUSY: ignored entirely (sides unchanged); OVR <= 1.
- REDUCE state, each cycle:
  - if rem>=sides: rem <= rem-sides (8-bit, no underflow possible).
  - else: result <= rem+1; result_valid pulses; DONE <= 1; BUSY <= 0; state <= IDLE.
- Roll latency: BUSY is high for floor(sample/sides)+1 cycles (max 128). result_valid asserts in the cycle after BUSY falls.
- Clear-on-read: rdata_used while addr==0x02 clears DONE, ERR and OVR. If a set event occurs in the same cycle, set wins.
- BUSY is not cleared by reads.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-roll -> busy=0, rdata=0x00, result=0x00, STATUS reads 0x00; after release, addr=0x00 -> rdata=0xD1 one cycle later.
- Deterministic d6: SEED write 0x00 (lfsr=0x00FF), then CTRL write 0x06 -> busy high 43 cycles, result=0x04, result_valid one pulse, STATUS=0x02.
- Deterministic d20: SEED write 0x14 (sample 0xEB), CTRL write 0x14 -> busy 12 cycles, RESULT reads 0x10.
- Boundary: SEED 0x00, CTRL 0xFF -> busy 2 cycles, result=0x01. CTRL 0x01 -> STATUS=0x04, no busy. rdata_used at addr 0x02 -> STATUS reads 0x00.
- Overrun: CTRL 0x06 then CTRL 0x0C while busy -> CTRL reads 0x06, STATUS=0x09 while busy, 0x0A on completion.
- Misc: SCRATCH write 0x5A reads back 0x5A; addr 0x07 reads 0xFF; a write to 0x07 changes nothing; a set event coincident with rdata_used leaves DONE=1.

Source files
------------

// File: rtl/i2c_dice_regs.sv
`default_nettype none
// ============================================================================
// i2c_dice_regs : I2C-mapped dice roller (LFSR sample reduced modulo N)
// Rev 1.0
// ============================================================================
module i2c_dice_regs #(
  parameter logic [7:0]  ID_VALUE   = 8'hD1,
  parameter logic [15:0] LFSR_RESET = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rw,
  input  logic [7:0] i_addr,
  input  logic       i_wen,
  input  logic [7:0] i_wdata,
  input  logic       i_rdata_used,
  output logic [7:0] o_rdata,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  output logic       o_busy
);

  localparam logic [7:0]  c_ADDR_ID      = 8'h00;
  localparam logic [7:0]  c_ADDR_CTRL    = 8'h01;
  localparam logic [7:0]  c_ADDR_STATUS  = 8'h02;
  localparam logic [7:0]  c_ADDR_RESULT  = 8'h03;
  localparam logic [7:0]  c_ADDR_SEED    = 8'h04;
  localparam logic [7:0]  c_ADDR_SCRATCH = 8'h05;
  localparam logic [15:0] c_TAPS         = 16'hB400;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REDUCE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_sides;
  logic [7:0]  r_rem;
  logic [7:0]  r_result;
  logic        r_result_valid;
  logic        r_done;
  logic        r_err;
  logic        r_ovr;
  logic [7:0]  r_scratch;
  logic [15:0] r_lfsr;
  logic        r_hold;
  logic [7:0]  r_rdata;

  logic        w_busy;
  logic        w_ctrl_wr;
  logic        w_seed_wr;
  logic        w_scratch_wr;
  logic        w_start;
  logic        w_reject;
  logic        w_overrun;
  logic        w_finish;
  logic        w_clr;
  logic [15:0] w_lfsr_step;
  logic [7:0]  w_status;
  logic [7:0]  w_rdata_nxt;
  logic        w_unused_rw;

  // Transaction direction is carried for completeness only.
  assign w_unused_rw  = i_rw;

  assign w_busy       = (r_state == S_REDUCE);
  assign w_ctrl_wr    = i_wen && (i_addr == c_ADDR_CTRL);
  assign w_seed_wr    = i_wen && (i_addr == c_ADDR_SEED);
  assign w_scratch_wr = i_wen && (i_addr == c_ADDR_SCRATCH);
  assign w_start      = w_ctrl_wr && !w_busy && (i_wdata >= 8'd2);
  assign w_reject     = w_ctrl_wr && !w_busy && (i_wdata < 8'd2);
  assign w_overrun    = w_ctrl_wr && w_busy;
  assign w_finish     = w_busy && (r_rem < r_sides);
  assign w_clr        = i_rdata_used && (i_addr == c_ADDR_STATUS);
  assign w_lfsr_step  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);
  assign w_status     = {4'b0000, r_ovr, r_err, r_done, w_busy};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start)  w_state_nxt = S_REDUCE;
      S_REDUCE: if (w_finish) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sides        <= 8'h00;
      r_rem          <= 8'h00;
      r_result       <= 8'h00;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= w_finish;
      if (w_ctrl_wr && !w_busy) r_sides <= i_wdata;
      if (w_start) begin
        r_rem <= r_lfsr[7:0];
      end else if (w_busy && !w_finish) begin
        r_rem <= r_rem - r_sides;
      end
      if (w_finish) r_result <= r_rem + 8'd1;
    end
  end

  // Set events take priority over clear-on-read of STATUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_finish  | (r_done & ~w_start & ~w_clr);
      r_err  <= w_reject  | (r_err & ~w_clr);
      r_ovr  <= w_overrun | (r_ovr & ~w_clr);
    end
  end

  // A seed freezes the LFSR so the next roll samples exactly the seeded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_RESET;
      r_hold <= 1'b0;
    end else begin
      if (w_seed_wr) begin
        r_lfsr <= {i_wdata, ~i_wdata};
        r_hold <= 1'b1;
      end else begin
        if (!r_hold) r_lfsr <= w_lfsr_step;
        if (w_start) r_hold <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_scratch <= 8'h00;
    else if (w_scratch_wr)  r_scratch <= i_wdata;
  end

  always_comb begin
    w_rdata_nxt = 8'hFF;
    case (i_addr)
      c_ADDR_ID:      w_rdata_nxt = ID_VALUE;
      c_ADDR_CTRL:    w_rdata_nxt = r_sides;
      c_ADDR_STATUS:  w_rdata_nxt = w_status;
      c_ADDR_RESULT:  w_rdata_nxt = r_result;
      c_ADDR_SEED:    w_rdata_nxt = 8'h00;
      c_ADDR_SCRATCH: w_rdata_nxt = r_scratch;
      default:        w_rdata_nxt = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= 8'h00;
    else        r_rdata <= w_rdata_nxt;
  end

  assign o_rdata        = r_rdata;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_dice_regs.sv
`default_nettype none
// ============================================================================
// tb_i2c_dice_regs : directed vector bench for the dice register bank
// Rev 1.0
// ============================================================================
module tb_i2c_dice_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_rw;
  logic [7:0] i_addr;
  logic       i_wen;
  logic [7:0] i_wdata;
  logic       i_rdata_used;
  logic [7:0] o_rdata;
  logic [7:0] o_result;
  logic       o_result_valid;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  i2c_dice_regs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rw           (i_rw),
    .i_addr         (i_addr),
    .i_wen          (i_wen),
    .i_wdata        (i_wdata),
    .i_rdata_used   (i_rdata_used),
    .o_rdata        (o_rdata),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    logic [7:0] sides;
    int         cycles;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    i_addr  = a;
    i_wdata = d;
    i_wen   = 1'b1;
    tick();
    i_wen   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    i_addr = a;
    tick();
    chk(name, {24'h0, o_rdata}, {24'h0, exp});
  endtask

  task automatic clr_status();
    i_addr       = 8'h02;
    i_rdata_used = 1'b1;
    tick();
    i_rdata_used = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Starts a roll and measures busy length, result and the result_valid pulse.
  task automatic roll(input string name, input logic [7:0] sides, input int exp_cycles,
                      input logic [7:0] exp_res);
    int  n;
    bit  spurious;
    n        = 0;
    spurious = 1'b0;
    wr(8'h01, sides);
    while (o_busy === 1'b1 && n < 300) begin
      if (o_result_valid !== 1'b0) spurious = 1'b1;
      n++;
      tick();
    end
    chk({name, "_busy_cycles"}, n, exp_cycles);
    chk({name, "_no_early_valid"}, {31'h0, spurious}, 32'd0);
    chk({name, "_valid_pulse"}, {31'h0, o_result_valid}, 32'd1);
    chk({name, "_result"}, {24'h0, o_result}, {24'h0, exp_res});
    tick();
    chk({name, "_valid_drop"}, {31'h0, o_result_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{seed: 8'h00, sides: 8'h06, cycles: 43,  res: 8'h04};
    vecs[1] = '{seed: 8'h14, sides: 8'h14, cycles: 12,  res: 8'h10};
    vecs[2] = '{seed: 8'h00, sides: 8'hFF, cycles: 2,   res: 8'h01};
    vecs[3] = '{seed: 8'hFF, sides: 8'h06, cycles: 1,   res: 8'h01};
    vecs[4] = '{seed: 8'h80, sides: 8'h02, cycles: 64,  res: 8'h02};
    vecs[5] = '{seed: 8'h00, sides: 8'h02, cycles: 128, res: 8'h02};

    rst_n = 1'b0; i_rw = 1'b0; i_addr = 8'h00; i_wen = 1'b0;
    i_wdata = 8'h00; i_rdata_used = 1'b0;
    repeat (3) tick();
    chk("rst_busy",   {31'h0, o_busy}, 32'd0);
    chk("rst_rdata",  {24'h0, o_rdata}, 32'h00);
    chk("rst_result", {24'h0, o_result}, 32'h00);
    chk("rst_valid",  {31'h0, o_result_valid}, 32'd0);
    rst_n = 1'b1;
    rd("rst_id", 8'h00, 8'hD1);
    rd("rst_status", 8'h02, 8'h00);

    for (int i = 0; i < 6; i++) begin
      clr_status();
      rd($sformatf("v%0d_pre_status", i), 8'h02, 8'h00);
      wr(8'h04, vecs[i].seed);
      repeat (3) tick();
      roll($sformatf("v%0d", i), vecs[i].sides, vecs[i].cycles, vecs[i].res);
      rd($sformatf("v%0d_status", i), 8'h02, 8'h02);
      rd($sformatf("v%0d_result_reg", i), 8'h03, vecs[i].res);
      rd($sformatf("v%0d_ctrl_reg", i), 8'h01, vecs[i].sides);
    end

    // Overrun: second CTRL write ignored, seed write mid-roll has no effect.
    clr_status();
    wr(8'h04, 8'h00);
    wr(8'h01, 8'h06);
    wr(8'h01, 8'h0C);
    rd("ovr_ctrl", 8'h01, 8'h06);
    rd("ovr_status_busy", 8'h02, 8'h09);
    wr(8'h04, 8'h33);
    wait_idle("ovr");
    chk("ovr_result", {24'h0, o_result}, 32'h04);
    rd("ovr_status_done", 8'h02, 8'h0A);

    // Illegal side count.
    clr_status();
    wr(8'h01, 8'h01);
    chk("err_no_busy", {31'h0, o_busy}, 32'd0);
    rd("err_status", 8'h02, 8'h04);
    rd("err_ctrl", 8'h01, 8'h01);
    clr_status();
    rd("err_cleared", 8'h02, 8'h00);

    // Misc register behaviour.
    wr(8'h05, 8'h5A);
    rd("scratch", 8'h05, 8'h5A);
    rd("seed_read", 8'h04, 8'h00);
    rd("unmapped", 8'h07, 8'hFF);
    wr(8'h07, 8'h12);
    rd("unmapped_wr_scratch", 8'h05, 8'h5A);
    rd("unmapped_wr_ctrl", 8'h01, 8'h01);
    rd("unmapped_wr_status", 8'h02, 8'h00);

    // Completion coincident with clear-on-read: DONE must survive.
    wr(8'h04, 8'h14);
    wr(8'h01, 8'h14);
    i_addr       = 8'h02;
    i_rdata_used = 1'b1;
    wait_idle("coinc");
    i_rdata_used = 1'b0;
    rd("coinc_status", 8'h02, 8'h02);

    // Asynchronous reset in the middle of a roll.
    wr(8'h04, 8'h00);
    wr(8'h01, 8'h06);
    repeat (5) tick();
    chk("mid_busy_before", {31'h0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy",   {31'h0, o_busy}, 32'd0);
    chk("mid_rst_rdata",  {24'h0, o_rdata}, 32'h00);
    chk("mid_rst_result", {24'h0, o_result}, 32'h00);
    tick();
    rst_n = 1'b1;
    rd("mid_rst_status", 8'h02, 8'h00);
    rd("mid_rst_ctrl", 8'h01, 8'h00);
    rd("mid_rst_id", 8'h00, 8'hD1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
